// File: rtl/conv_seq_unit_pkg.sv
// Shared configuration for the convolution window sequencer: field widths, one-hot state
// encoding and zero-extension helpers. CONV_SEQ_CFG_CHECK_EN enables the cfg_err checker.
package conv_seq_unit_pkg;

  localparam int TENSOR_SIZE = 8;
  localparam int KERNEL_SIZE = 4;
  localparam int STRIDE_SIZE = 4;

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    CALC = 5'b00010,
    PARA = 5'b00100,
    SCAN = 5'b01000,
    DONE = 5'b10000
  } state_t;

  function automatic logic [TENSOR_SIZE-1:0] ext_s(input logic [STRIDE_SIZE-1:0] s);
    return {{(TENSOR_SIZE-STRIDE_SIZE){1'b0}}, s};
  endfunction

  function automatic logic [TENSOR_SIZE-1:0] ext_k(input logic [KERNEL_SIZE-1:0] k);
    return {{(TENSOR_SIZE-KERNEL_SIZE){1'b0}}, k};
  endfunction

endpackage

// File: rtl/conv_ofs_div.sv
// Repeated-subtraction divider computing floor((T-K)/S), one subtraction per enabled step.
// done is high once the remainder drops below the divisor; quot then holds the result.
module conv_ofs_div
  import conv_seq_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   step,
  input  logic [TENSOR_SIZE-1:0] init_rem,
  input  logic [STRIDE_SIZE-1:0] divisor,
  output logic                   done,
  output logic [TENSOR_SIZE-1:0] quot
);

  logic [TENSOR_SIZE-1:0] rem;

  assign done = (rem < ext_s(divisor));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem  <= '0;
      quot <= '0;
    end else if (enable) begin
      if (load) begin
        rem  <= init_rem;
        quot <= '0;
      end else if (step && !done) begin
        rem  <= rem - ext_s(divisor);
        quot <= quot + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_seq_unit.sv
// Convolution window sequencer: computes the last output index, then streams window origins
// row-major over a valid/ready port. CONV_SEQ_CFG_CHECK_EN adds cfg_err for K>T or S==0.
module conv_seq_unit
  import conv_seq_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   start_conv,
  input  logic [TENSOR_SIZE-1:0] tensor_size,
  input  logic [KERNEL_SIZE-1:0] kernel_size,
  input  logic [STRIDE_SIZE-1:0] stride,
  output logic [TENSOR_SIZE-1:0] n_ofs,
  output logic                   n_para_done,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [TENSOR_SIZE-1:0] win_y,
  output logic [TENSOR_SIZE-1:0] win_x,
  output logic                   win_last,
  output logic                   w_done,
  output logic                   busy,
  output state_t                 dbg_state
`ifdef CONV_SEQ_CFG_CHECK_EN
  ,
  output logic                   cfg_err
`endif
);

  // Window port: a transfer happens on a rising clk edge where win_valid, win_ready and
  // enable are all high; win_x/win_y/win_last stay constant until that transfer occurs.

  state_t                 state, state_n;
  logic                   start_q, rise, load, div_done, hs, at_last, cfg_bad;
  logic [TENSOR_SIZE-1:0] quot, row, col, x_acc, y_acc;
  logic [STRIDE_SIZE-1:0] s_q;

  assign rise    = start_conv && !start_q;
  assign load    = enable && rise && (state == IDLE);
  assign at_last = (row == n_ofs) && (col == n_ofs);
  assign hs      = win_valid && win_ready && enable;

`ifdef CONV_SEQ_CFG_CHECK_EN
  assign cfg_bad = (ext_k(kernel_size) > tensor_size) || (stride == '0);
`else
  assign cfg_bad = 1'b0;
`endif

  conv_ofs_div u_div (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .load     (load),
    .step     (state == CALC),
    .init_rem (tensor_size - ext_k(kernel_size)),
    .divisor  (s_q),
    .done     (div_done),
    .quot     (quot)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // start_conv dropping while a run is in flight withdraws it silently.
  always_comb begin
    state_n = state;
    if (enable) begin
      case (state)
        IDLE:    if (rise) state_n = cfg_bad ? DONE : CALC;
        CALC:    if (!start_conv) state_n = IDLE;
                 else if (div_done) state_n = PARA;
        PARA:    state_n = start_conv ? SCAN : IDLE;
        SCAN:    if (!start_conv) state_n = IDLE;
                 else if (win_ready && at_last) state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    win_valid   = (state == SCAN);
    n_para_done = (state == PARA);
    w_done      = (state == DONE);
    win_last    = win_valid && at_last;
    win_x       = win_valid ? x_acc : '0;
    win_y       = win_valid ? y_acc : '0;
    dbg_state   = state;
  end

  // Origins are built by adding the stride, so no multiplier is needed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q <= 1'b0;
      s_q     <= '0;
      n_ofs   <= '0;
      row     <= '0;
      col     <= '0;
      x_acc   <= '0;
      y_acc   <= '0;
    end else if (enable) begin
      start_q <= start_conv;
      if (load) s_q <= stride;
      if (state == CALC && state_n == PARA) n_ofs <= quot;
      if (state == PARA) begin
        row   <= '0;
        col   <= '0;
        x_acc <= '0;
        y_acc <= '0;
      end else if (hs) begin
        if (col == n_ofs) begin
          col   <= '0;
          x_acc <= '0;
          row   <= row + 1'b1;
          y_acc <= y_acc + ext_s(s_q);
        end else begin
          col   <= col + 1'b1;
          x_acc <= x_acc + ext_s(s_q);
        end
      end
    end
  end

`ifdef CONV_SEQ_CFG_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     cfg_err <= 1'b0;
    else if (load) cfg_err <= cfg_bad;
  end
`endif

endmodule

// File: doc/conv_seq_unit.md
CONV_SEQ_UNIT -- requirements
Module: conv_seq_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rising edge only.
REQ-002 SHALL have: rstn  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have: enable  in  1  global advance qualifier; low freezes all state and outputs.
REQ-004 SHALL have: start_conv  in  1  level run request from the control unit; stays high until w_done is seen.
REQ-005 SHALL have: tensor_size  in  TENSOR_SIZE  input feature edge T; kernel_size  in  KERNEL_SIZE  kernel edge K; stride  in  STRIDE_SIZE  stride S.
REQ-006 SHALL have: n_ofs  out  TENSOR_SIZE  last output index, floor((T-K)/S); n_para_done  out  1  one-cycle pulse, n_ofs valid.
REQ-007 SHALL have: win_valid  out  1; win_ready  in  1; win_y, win_x  out  TENSOR_SIZE  window origin pixel; win_last  out  1  final window.
REQ-008 SHALL have: w_done  out  1  one-cycle pulse, all windows delivered; busy  out  1  high in any state other than IDLE.

Function
REQ-009 SHALL use the states IDLE, CALC, PARA, SCAN, DONE, one-hot encoded, and SHALL advance only in cycles with enable=1.
REQ-010 SHALL register start_conv and detect a rising edge (0->1) only in enable cycles; start_conv held high SHALL NOT retrigger.
REQ-011 SHALL, on a rising edge in IDLE, capture T, K and S, load rem=T-K and q=0, and enter CALC.
REQ-012 SHALL, in CALC, perform one step per enabled cycle: if rem>=S, then rem-=S and q+=1; otherwise n_ofs<=q and go to PARA. Latency is q+1 enabled cycles, with no divider or multiplier.
REQ-013 SHALL assert n_para_done for exactly one cycle in PARA, hold n_ofs until the next capture, and enter SCAN on the next enabled cycle.
REQ-014 SHALL, in SCAN, emit windows in row-major order (col 0..n_ofs inside row 0..n_ofs): win_x=col*S and win_y=row*S, built by stride accumulation.
REQ-015 SHALL hold win_valid high in SCAN; a handshake is win_valid&&win_ready&&enable. The payload SHALL stay stable until the handshake.
REQ-016 SHALL assert win_last with the window row=col=n_ofs; its handshake SHALL move to DONE.
REQ-017 SHALL pulse w_done for one cycle in DONE, then return to IDLE. Window count is (n_ofs+1)^2.
REQ-018 SHALL abort to IDLE without w_done or n_para_done if start_conv is sampled low in CALC, PARA or SCAN.
REQ-019 SHALL handle T==K with n_ofs=0, which gives a single window (0,0) that has win_last set.
REQ-020 SHALL ignore a rising start_conv edge outside IDLE.

Reset
REQ-021 SHALL, with rstn low, immediately force IDLE and zero all of: n_ofs, n_para_done, w_done, win_valid, win_last, win_x, win_y, busy, and the internal counters and edge register.
REQ-022 SHALL abandon any operation in progress on reset, with no pulse emitted.

Configuration
REQ-023 SHALL support macro CONV_SEQ_CFG_CHECK_EN; when it is defined, an output cfg_err (1 bit) exists.
REQ-024 SHALL, with CONV_SEQ_CFG_CHECK_EN defined, check each capture for K>T or S==0. On a failure it SHALL set cfg_err, skip CALC/SCAN, pulse w_done, and return to IDLE. cfg_err SHALL clear at the next capture or on reset.
REQ-025 SHALL, without the macro, have no cfg_err port and no check. Behaviour for K>T or S==0 is unspecified.

Structure
REQ-026 SHALL take TENSOR_SIZE, KERNEL_SIZE and STRIDE_SIZE from the shared config header, and SHALL place the state encodings in that shared header as well.
REQ-027 SHALL be split into an optional sub-module conv_ofs_div, the repeated-subtraction divider for CALC. All other logic SHALL be flat.

Verification
REQ-028 T=8, K=3, S=1, with win_ready always 1: n_ofs=5, n_para_done once, 36 windows, last (5,5) with win_last, then w_done 1 cycle later.
REQ-029 T=7, K=3, S=2: n_ofs=2, origins x,y in {0,2,4}, 9 windows, CALC lasts 3 cycles.
REQ-030 T=4, K=4, S=1: n_ofs=0, a single window (0,0) with win_last, then w_done.
REQ-031 Random win_ready and enable toggling: payload stable while stalled, no lost or duplicate windows, sequence matches the model.
REQ-032 Assert rstn mid-SCAN, and separately drop start_conv mid-SCAN: IDLE next cycle, outputs zero, no w_done; a subsequent start runs cleanly.
REQ-033 With CONV_SEQ_CFG_CHECK_EN defined, T=3, K=5: cfg_err=1, no windows, w_done pulse; the next valid start clears cfg_err.
